vdp_super_half_2ppb_writer: RTL and testbench

- Pixel-span writer for the 720-wide, 4-bit-per-pixel (two pixels per byte) super-res framebuffer.
- The display scan-out reads this framebuffer. This block is the write side of the same layout.
- Accepts horizontal span-fill commands (x, y, length, colour) from the command engine / CPU port.
- Emits 32-bit word writes to VRAM, with byte masks. Partial-byte (single-nibble) edges use read-modify-write.
- Framebuffer layout:
  - Word address = page_addr + y*90 + x/8.
  - Pixel p (0..7) within a word occupies bits [8*(p>>1) + (p[0] ? 0 : 4) +: 4]: pixel 0 = [7:4], pixel 1 = [3:0], pixel 2 = [15:12], and so on.

---
 rtl/vdp_super_half_2ppb_writer.sv | 180 ++++++++++++++++++
 tb/tb_vdp_super_half_2ppb_writer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vdp_super_half_2ppb_writer.sv
// vdp_super_half_2ppb_writer: span-fill writer for the 720x4bpp super-res framebuffer (optional SUPER_WRITER_XOR_EN adds cmd_xor)
module vdp_super_half_2ppb_writer #(
   parameter int LINE_PIXELS = 720,
   parameter int LINE_WORDS  = 90
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pal_mode,
   input  logic [16:0] page_addr,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_x,
   input  logic [8:0]  cmd_y,
   input  logic [9:0]  cmd_len,
   input  logic [3:0]  cmd_colour,
`ifdef SUPER_WRITER_XOR_EN
   input  logic        cmd_xor,
`endif
   output logic        busy,
   output logic        done,
   output logic        done_err,
   output logic [17:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);
   typedef enum logic [2:0] {IDLE, SETUP, WORD, READ, WRITE, DONE} state_t;

   state_t      state_q, state_d;
   logic [9:0]  x_q, x_d, len_q, len_d, cur_q, cur_d;
   logic [8:0]  y_q, y_d;
   logic [3:0]  col_q, col_d, wmask_q, wmask_d;
   logic [16:0] page_q, page_d;
   logic [10:0] end_q, end_d;
   logic [17:0] addr_q, addr_d;
   logic [7:0]  nm_q, nm_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d, xor_q, xor_d, cmd_xor_w;

   logic [10:0] base, last, sum, end_x;
   logic [2:0]  hi;
   logic [7:0]  nm;
   logic [3:0]  full, part, touch;
   logic [31:0] merged;
   logic [17:0] y90;
   logic        reject;

`ifdef SUPER_WRITER_XOR_EN
   assign cmd_xor_w = cmd_xor;
`else
   assign cmd_xor_w = 1'b0;
`endif

   assign cmd_ready = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign done_err  = (state_q == DONE) && err_q;
   assign mem_rd    = state_q == READ;
   assign mem_wr    = state_q == WRITE;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;

   // Span setup: reject test, clipped end and start word address
   assign reject = (x_q >= 10'(LINE_PIXELS)) || (y_q >= (pal_mode ? 9'd288 : 9'd240)) || (len_q == 10'd0);
   assign sum    = 11'(x_q) + 11'(len_q);
   assign end_x  = (sum > 11'(LINE_PIXELS)) ? 11'(LINE_PIXELS) : sum;
   assign y90    = (LINE_WORDS == 90) ? (18'(y_q) << 6) + (18'(y_q) << 4) + (18'(y_q) << 3) + (18'(y_q) << 1)
                                      : 18'(y_q) * 18'(LINE_WORDS);

   // Pixels covered in the current word: cur_x[2:0] up to the last span pixel, capped at 7
   assign base = {1'b0, cur_q[9:3], 3'b000};
   assign last = end_q - 11'd1 - base;
   assign hi   = (last > 11'd7) ? 3'd7 : last[2:0];
   assign nm   = (8'hFF << cur_q[2:0]) & (8'hFF >> (3'd7 - hi));

   // Even pixel sits in the high nibble of its byte, odd pixel in the low nibble
   for (genvar p = 0; p < 8; p++) begin : g_pix
      localparam int N = 8 * (p / 2) + ((p % 2) != 0 ? 0 : 4);
      assign merged[N +: 4] = nm_q[p] ? (xor_q ? mem_rdata[N +: 4] ^ col_q : col_q) : mem_rdata[N +: 4];
   end

   for (genvar b = 0; b < 4; b++) begin : g_byte
      assign full[b]  = nm[2*b] & nm[2*b+1];
      assign part[b]  = nm[2*b] ^ nm[2*b+1];
      assign touch[b] = nm_q[2*b] | nm_q[2*b+1];
   end

   // Next-state and datapath updates for the span FSM
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      len_d   = len_q;
      col_d   = col_q;
      page_d  = page_q;
      xor_d   = xor_q;
      end_d   = end_q;
      cur_d   = cur_q;
      addr_d  = addr_q;
      nm_d    = nm_q;
      wdata_d = wdata_q;
      wmask_d = wmask_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (cmd_valid) begin
            x_d     = cmd_x;
            y_d     = cmd_y;
            len_d   = cmd_len;
            col_d   = cmd_colour;
            page_d  = page_addr;
            xor_d   = cmd_xor_w;
            state_d = SETUP;
         end
         SETUP: begin
            err_d   = reject;
            end_d   = end_x;
            cur_d   = x_q;
            addr_d  = 18'(page_q) + y90 + 18'(x_q[9:3]);
            state_d = reject ? DONE : WORD;
         end
         WORD: begin
            nm_d    = nm;
            wdata_d = {8{col_q}};
            wmask_d = full;
            state_d = (|part || xor_q) ? READ : WRITE;
         end
         READ: if (mem_ack) begin
            wdata_d = merged;
            wmask_d = touch;
            state_d = WRITE;
         end
         WRITE: if (mem_ack) begin
            cur_d   = {cur_q[9:3] + 7'd1, 3'b000};
            addr_d  = addr_q + 18'd1;
            state_d = ({1'b0, cur_d} >= end_q) ? DONE : WORD;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset also aborts any memory request
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         len_q   <= '0;
         col_q   <= '0;
         page_q  <= '0;
         xor_q   <= 1'b0;
         end_q   <= '0;
         cur_q   <= '0;
         addr_q  <= '0;
         nm_q    <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         len_q   <= len_d;
         col_q   <= col_d;
         page_q  <= page_d;
         xor_q   <= xor_d;
         end_q   <= end_d;
         cur_q   <= cur_d;
         addr_q  <= addr_d;
         nm_q    <= nm_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         err_q   <= err_d;
      end
   end
endmodule

// File: tb/tb_vdp_super_half_2ppb_writer.sv
// tb_vdp_super_half_2ppb_writer: scoreboarded directed bench for the span writer
module tb_vdp_super_half_2ppb_writer;
   logic        clk, reset_n, pal_mode, cmd_valid, cmd_ready, busy, done, done_err;
   logic [16:0] page_addr;
   logic [9:0]  cmd_x, cmd_len;
   logic [8:0]  cmd_y;
   logic [3:0]  cmd_colour, mem_wmask;
   logic [17:0] mem_addr;
   logic        mem_rd, mem_wr, mem_ack;
   logic [31:0] mem_wdata, mem_rdata;

   typedef struct {bit wr; logic [17:0] addr; logic [31:0] wdata; logic [3:0] mask;} txn_t;
   txn_t exp_q[$];

   int vectors = 0, miscompares = 0, lat = 0, wcnt = 0;
   logic [31:0] rdata_v = '0;

   vdp_super_half_2ppb_writer dut (
      .clk(clk), .reset_n(reset_n), .pal_mode(pal_mode), .page_addr(page_addr),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_x(cmd_x), .cmd_y(cmd_y),
      .cmd_len(cmd_len), .cmd_colour(cmd_colour),
`ifdef SUPER_WRITER_XOR_EN
      .cmd_xor(1'b0),
`endif
      .busy(busy), .done(done), .done_err(done_err), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit wr, input logic [17:0] a, input logic [31:0] d, input logic [3:0] m);
      txn_t t;
      t.wr = wr; t.addr = a; t.wdata = d; t.mask = m;
      exp_q.push_back(t);
   endtask

   // Memory model: acks after lat wait cycles and checks each request against the scoreboard
   initial begin
      txn_t t;
      mem_ack = 0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 0;
         if (!reset_n || !(mem_rd || mem_wr)) wcnt = 0;
         else begin
            chk("rd_wr_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
            if (wcnt < lat) wcnt++;
            else begin
               wcnt = 0;
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $error("FAIL unexpected_req: observed rd=%b wr=%b addr 0x%0h expected no request", mem_rd, mem_wr, mem_addr);
               end else begin
                  t = exp_q.pop_front();
                  chk("req_kind_wr", {31'b0, mem_wr}, {31'b0, t.wr});
                  chk("req_addr", {14'b0, mem_addr}, {14'b0, t.addr});
                  if (t.wr) begin
                     chk("wdata", mem_wdata, t.wdata);
                     chk("wmask", {28'b0, mem_wmask}, {28'b0, t.mask});
                  end
               end
               mem_rdata = rdata_v;
               mem_ack = 1;
            end
         end
      end
   end

   task automatic run_cmd(input int x, input int y, input int len, input int col, input int page,
                          input bit pal, input bit err, input int cycles);
      int n;
      bit got;
      @(negedge clk);
      chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
      pal_mode = pal; cmd_x = 10'(x); cmd_y = 9'(y); cmd_len = 10'(len);
      cmd_colour = 4'(col); page_addr = 17'(page); cmd_valid = 1;
      @(posedge clk);
      #1;
      cmd_valid = 0;
      cmd_x = 10'($urandom); cmd_y = 9'($urandom); cmd_len = 10'($urandom);
      cmd_colour = 4'($urandom); page_addr = 17'($urandom);
      n = 0;
      got = 0;
      while (n < 500 && !got) begin
         @(negedge clk);
         n++;
         if (done) got = 1;
      end
      chk("done_seen", {31'b0, got}, 32'd1);
      if (got) begin
         chk("done_err", {31'b0, done_err}, {31'b0, err});
         chk("busy_at_done", {31'b0, busy}, 32'd1);
         if (cycles >= 0) chk("done_latency", n, cycles);
      end
      @(negedge clk);
      chk("done_one_pulse", {31'b0, done}, 32'd0);
      chk("busy_after", {31'b0, busy}, 32'd0);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset_n = 1; pal_mode = 0; page_addr = '0; cmd_valid = 0;
      cmd_x = '0; cmd_y = '0; cmd_len = '0; cmd_colour = '0;
      #1 reset_n = 0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {30'b0, done, done_err}, 32'd0);
      chk("rst_rd_wr", {30'b0, mem_rd, mem_wr}, 32'd0);
      chk("rst_addr", {14'b0, mem_addr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_wmask", {28'b0, mem_wmask}, 32'd0);
      reset_n = 1;

      lat = 0; rdata_v = 32'hFFFFFFFF;
      push(0, 18'd0, 0, 0); push(1, 18'd0, 32'hFFFFFF5F, 4'b0001);
      run_cmd(0, 0, 1, 5, 0, 0, 0, -1);

      lat = 2;
      push(1, 18'h15B, 32'hAAAAAAAA, 4'b1111);
      run_cmd(8, 1, 8, 10, 'h100, 0, 0, -1);

      lat = 1;
      push(1, 18'd0, 32'h33333333, 4'b1110); push(1, 18'd1, 32'h33333333, 4'b0111);
      run_cmd(2, 0, 12, 3, 0, 0, 0, -1);

      lat = 0; rdata_v = 32'h0;
      push(0, 18'h59, 0, 0); push(1, 18'h59, 32'h77770700, 4'b1110);
      run_cmd(715, 0, 10, 7, 0, 0, 0, -1);

      rdata_v = 32'h12345678;
      push(0, 18'd0, 0, 0); push(1, 18'd0, 32'h12346676, 4'b0011);
      run_cmd(1, 0, 2, 6, 0, 0, 0, -1);

      lat = 3;
      push(1, 18'h10B4, 32'hCCCCCCCC, 4'b1100);
      push(1, 18'h10B5, 32'hCCCCCCCC, 4'b1111);
      push(1, 18'h10B6, 32'hCCCCCCCC, 4'b1111);
      run_cmd(4, 2, 20, 12, 'h1000, 0, 0, -1);

      lat = 0;
      run_cmd(0, 240, 8, 1, 0, 0, 1, 2);
      run_cmd(5, 0, 0, 1, 0, 0, 1, 2);
      run_cmd(720, 0, 4, 1, 0, 0, 1, 2);
      run_cmd(0, 288, 8, 1, 0, 1, 1, 2);

      push(1, 18'd25830, 32'h99999999, 4'b1111);
      run_cmd(0, 287, 8, 9, 0, 1, 0, -1);
      push(1, 18'd21510, 32'h44444444, 4'b1111);
      run_cmd(0, 239, 8, 4, 0, 0, 0, -1);

      lat = 6; rdata_v = 32'h0;
      @(negedge clk);
      cmd_x = 0; cmd_y = 0; cmd_len = 1; cmd_colour = 2; page_addr = 0; pal_mode = 0; cmd_valid = 1;
      @(posedge clk);
      #1 cmd_valid = 0;
      n = 0;
      while (n < 50 && !mem_rd) begin
         @(negedge clk);
         n++;
      end
      chk("rd_raised", {31'b0, mem_rd}, 32'd1);
      #2 reset_n = 0;
      #1;
      chk("rd_drops_async", {31'b0, mem_rd}, 32'd0);
      chk("wr_low_in_reset", {31'b0, mem_wr}, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      chk("rst2_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst2_busy", {31'b0, busy}, 32'd0);
      reset_n = 1;

      lat = 1;
      push(1, 18'h15B, 32'hBBBBBBBB, 4'b1111);
      run_cmd(8, 1, 8, 11, 'h100, 0, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
